// File: rtl/control_sequencer_pkg.sv
// Shared types for the control sequencer: opcode constants, opcode classes,
// FSM states and the pcSource / faultCode encodings.
package control_sequencer_pkg;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  typedef enum logic [3:0] {
    CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH, CLS_LOAD,
    CLS_STORE, CLS_OPIMM, CLS_OP, CLS_MISCMEM, CLS_SYSTEM, CLS_ILLEGAL
  } opClassType;

  typedef enum logic [2:0] {
    ST_INIT, ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEMORY, ST_WRITEBACK, ST_HALT
  } seqStateType;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
  localparam logic [1:0] FAULT_BUS     = 2'd2;
  localparam logic [1:0] FAULT_SYSTEM  = 2'd3;

endpackage

// File: rtl/control_sequencer_opcode_classifier.sv
// Combinational opcode classifier: maps instruction[6:0] to an opcode class.
// SYSTEM counts as legal; only unknown encodings clear the legal flag.
module opcode_classifier
  import control_sequencer_pkg::*;
(
  input  logic [6:0] opcode,
  output opClassType opcodeClass,
  output logic       legal
);

  always_comb begin
    opcodeClass = CLS_ILLEGAL;
    legal       = 1'b1;
    case (opcode)
      OPC_LUI:     opcodeClass = CLS_LUI;
      OPC_AUIPC:   opcodeClass = CLS_AUIPC;
      OPC_JAL:     opcodeClass = CLS_JAL;
      OPC_JALR:    opcodeClass = CLS_JALR;
      OPC_BRANCH:  opcodeClass = CLS_BRANCH;
      OPC_LOAD:    opcodeClass = CLS_LOAD;
      OPC_STORE:   opcodeClass = CLS_STORE;
      OPC_OPIMM:   opcodeClass = CLS_OPIMM;
      OPC_OP:      opcodeClass = CLS_OP;
      OPC_MISCMEM: opcodeClass = CLS_MISCMEM;
      OPC_SYSTEM:  opcodeClass = CLS_SYSTEM;
      default: begin
        opcodeClass = CLS_ILLEGAL;
        legal       = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle core control FSM: fetch/decode/execute/memory/writeback with a
// memReady wait timeout, sticky halt with fault code, and a retired counter.
// Handshake: a memory request (memReadEnable/memWriteEnable) is held every
// cycle until memReady=1 is seen in a FETCH/MEMORY cycle; that cycle completes it.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
)
(
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        memReady,
  input  logic        branchTaken,
  output logic        instructionLatchEnable,
  output logic        memReadEnable,
  output logic        memWriteEnable,
  output logic        rdWriteEnable,
  output logic        pcWriteEnable,
  output logic [1:0]  pcSource,
  output logic        halted,
  output logic [1:0]  faultCode,
  output logic [31:0] retiredCount,
  output seqStateType stateDebug
);

  seqStateType state;
  opClassType  instrClass;
  opClassType  decodedClass;
  logic        decodedLegal;
  logic        resetReleased;
  logic [31:0] waitCount;
  logic        timeoutHit;
  logic        isMemClass;

  opcode_classifier u_classifier (
    .opcode      (opcode),
    .opcodeClass (decodedClass),
    .legal       (decodedLegal)
  );

  // memReady=1 takes priority: a timeout only fires on a cycle still waiting.
  assign timeoutHit = (TIMEOUT_CYCLES != 0) && !memReady &&
                      (waitCount == 32'(TIMEOUT_CYCLES - 1));
  assign isMemClass = (instrClass == CLS_LOAD) || (instrClass == CLS_STORE);
  assign stateDebug = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_INIT;
      instrClass    <= CLS_ILLEGAL;
      resetReleased <= 1'b0;
      waitCount     <= 32'd0;
      retiredCount  <= 32'd0;
      faultCode     <= FAULT_NONE;
    end else begin
      case (state)
        // One extra INIT cycle after release so FETCH starts on the second edge.
        ST_INIT: begin
          resetReleased <= 1'b1;
          waitCount     <= 32'd0;
          if (resetReleased) state <= ST_FETCH;
        end
        ST_FETCH, ST_MEMORY: begin
          if (memReady) begin
            waitCount <= 32'd0;
            state     <= (state == ST_FETCH) ? ST_DECODE : ST_WRITEBACK;
          end else if (timeoutHit) begin
            faultCode <= FAULT_BUS;
            state     <= ST_HALT;
          end else begin
            waitCount <= waitCount + 32'd1;
          end
        end
        ST_DECODE: begin
          instrClass <= decodedClass;
          if (!decodedLegal) begin
            faultCode <= FAULT_ILLEGAL;
            state     <= ST_HALT;
          end else if (decodedClass == CLS_SYSTEM) begin
            faultCode <= FAULT_SYSTEM;
            state     <= ST_HALT;
          end else begin
            state <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          waitCount <= 32'd0;
          state     <= isMemClass ? ST_MEMORY : ST_WRITEBACK;
        end
        ST_WRITEBACK: begin
          retiredCount <= retiredCount + 32'd1;
          waitCount    <= 32'd0;
          state        <= ST_FETCH;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_HALT;
      endcase
    end
  end

  always_comb begin
    instructionLatchEnable = 1'b0;
    memReadEnable          = 1'b0;
    memWriteEnable         = 1'b0;
    rdWriteEnable          = 1'b0;
    pcWriteEnable          = 1'b0;
    pcSource               = PC_PLUS4;
    halted                 = (state == ST_HALT);
    case (state)
      ST_FETCH: begin
        memReadEnable          = 1'b1;
        instructionLatchEnable = memReady;
      end
      ST_MEMORY: begin
        memReadEnable  = (instrClass == CLS_LOAD);
        memWriteEnable = (instrClass == CLS_STORE);
      end
      ST_WRITEBACK: begin
        pcWriteEnable = 1'b1;
        rdWriteEnable = !((instrClass == CLS_BRANCH) || (instrClass == CLS_STORE) ||
                          (instrClass == CLS_MISCMEM));
        if ((instrClass == CLS_JAL) || ((instrClass == CLS_BRANCH) && branchTaken))
          pcSource = PC_IMM;
        else if (instrClass == CLS_JALR)
          pcSource = PC_JALR;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-instruction behavioural model
// pushes the expected output vector for every cycle; one process compares.
module tb_control_sequencer;

  localparam int TIMEOUT = 4;
  localparam int W = 42;

  localparam logic [6:0] T_LUI = 7'b0110111, T_AUIPC = 7'b0010111, T_JAL = 7'b1101111;
  localparam logic [6:0] T_JALR = 7'b1100111, T_BRANCH = 7'b1100011, T_LOAD = 7'b0000011;
  localparam logic [6:0] T_STORE = 7'b0100011, T_OPIMM = 7'b0010011, T_OP = 7'b0110011;
  localparam logic [6:0] T_MISCMEM = 7'b0001111, T_SYSTEM = 7'b1110011;
  localparam logic [6:0] EXEC_OPS [10] = '{T_LUI, T_AUIPC, T_JAL, T_JALR, T_BRANCH,
                                           T_LOAD, T_STORE, T_OPIMM, T_OP, T_MISCMEM};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode = 7'd0;
  logic        memReady = 1'b0;
  logic        branchTaken = 1'b0;
  logic        instructionLatchEnable, memReadEnable, memWriteEnable;
  logic        rdWriteEnable, pcWriteEnable, halted;
  logic [1:0]  pcSource, faultCode;
  logic [31:0] retiredCount;
  logic [2:0]  stateDebug;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] actVec;
  int nVectors = 0;
  int nMiscompares = 0;

  // Behavioural model state
  logic [31:0] mRetired = 32'd0;
  logic        mHalted = 1'b0;
  logic [1:0]  mFault = 2'd0;

  control_sequencer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .opcode                 (opcode),
    .memReady               (memReady),
    .branchTaken            (branchTaken),
    .instructionLatchEnable (instructionLatchEnable),
    .memReadEnable          (memReadEnable),
    .memWriteEnable         (memWriteEnable),
    .rdWriteEnable          (rdWriteEnable),
    .pcWriteEnable          (pcWriteEnable),
    .pcSource               (pcSource),
    .halted                 (halted),
    .faultCode              (faultCode),
    .retiredCount           (retiredCount),
    .stateDebug             (stateDebug)
  );

  always #5 clock = ~clock;

  assign actVec = {instructionLatchEnable, memReadEnable, memWriteEnable, rdWriteEnable,
                   pcWriteEnable, pcSource, halted, faultCode, retiredCount};

  function automatic logic [W-1:0] mk(input logic ile, input logic mre, input logic mwe,
                                      input logic rde, input logic pce, input logic [1:0] pcs);
    return {ile, mre, mwe, rde, pce, pcs, mHalted, mFault, mRetired};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rndOpc();
    return 7'($urandom_range(0, 127));
  endfunction

  function automatic logic isExec(input logic [6:0] opc);
    for (int i = 0; i < 10; i++)
      if (EXEC_OPS[i] == opc) return 1'b1;
    return 1'b0;
  endfunction

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
    nVectors++;
    if (act !== req) begin
      nMiscompares++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock cycle: inputs change 1ns after the rising edge; expectation queued.
  task automatic tick(input logic rst, input logic mr, input logic bt,
                      input logic [6:0] opc, input logic [W-1:0] e);
    @(posedge clock);
    #1;
    reset = rst;
    memReady = mr;
    branchTaken = bt;
    opcode = opc;
    exp_q.push_back(e);
  endtask

  task automatic doReset(input int hold);
    mRetired = 32'd0;
    mHalted  = 1'b0;
    mFault   = 2'd0;
    tick(1'b1, rb(), rb(), rndOpc(), mk(0, 0, 0, 0, 0, 2'd0));
    @(negedge clock);
    lit("reset_memWrite", {31'd0, memWriteEnable}, 32'd0);
    lit("reset_retired", retiredCount, 32'd0);
    repeat (hold) tick(1'b1, rb(), rb(), rndOpc(), mk(0, 0, 0, 0, 0, 2'd0));
    tick(1'b0, rb(), rb(), rndOpc(), mk(0, 0, 0, 0, 0, 2'd0));
    tick(1'b0, rb(), rb(), rndOpc(), mk(0, 0, 0, 0, 0, 2'd0));
  endtask

  task automatic haltIdle(input int n);
    repeat (n) tick(1'b0, rb(), rb(), rndOpc(), mk(0, 0, 0, 0, 0, 2'd0));
  endtask

  // Runs one instruction from its first FETCH cycle; returns in its last cycle.
  task automatic execInstr(input logic [6:0] opc, input int fetchWaits, input int memWaits,
                           input logic taken, input int resetAt);
    logic isLoad, isStore, rde;
    logic [1:0] pcs;
    isLoad  = (opc == T_LOAD);
    isStore = (opc == T_STORE);
    for (int i = 0; i < fetchWaits; i++) begin
      tick(1'b0, 1'b0, rb(), rndOpc(), mk(0, 1, 0, 0, 0, 2'd0));
      if (i + 1 == TIMEOUT) begin mHalted = 1'b1; mFault = 2'd2; return; end
    end
    tick(1'b0, 1'b1, rb(), rndOpc(), mk(1, 1, 0, 0, 0, 2'd0));
    tick(1'b0, rb(), rb(), opc, mk(0, 0, 0, 0, 0, 2'd0));
    if (opc == T_SYSTEM) begin mHalted = 1'b1; mFault = 2'd3; return; end
    if (!isExec(opc)) begin mHalted = 1'b1; mFault = 2'd1; return; end
    tick(1'b0, rb(), rb(), rndOpc(), mk(0, 0, 0, 0, 0, 2'd0));
    if (isLoad || isStore) begin
      for (int i = 0; i < memWaits; i++) begin
        if (i == resetAt) begin doReset(1); return; end
        tick(1'b0, 1'b0, rb(), rndOpc(), mk(0, isLoad, isStore, 0, 0, 2'd0));
        if (i + 1 == TIMEOUT) begin mHalted = 1'b1; mFault = 2'd2; return; end
      end
      tick(1'b0, 1'b1, rb(), rndOpc(), mk(0, isLoad, isStore, 0, 0, 2'd0));
    end
    rde = !(opc == T_BRANCH || opc == T_STORE || opc == T_MISCMEM);
    pcs = (opc == T_JAL) ? 2'd1 : (opc == T_JALR) ? 2'd2 :
          (opc == T_BRANCH && taken) ? 2'd1 : 2'd0;
    tick(1'b0, rb(), taken, rndOpc(), mk(0, 0, 0, rde, 1, pcs));
    mRetired = mRetired + 32'd1;
  endtask

  initial begin : compare_proc
    logic [W-1:0] e;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        nVectors++;
        if (actVec !== e) begin
          nMiscompares++;
          $display("FAIL cycle_vector t=%0t actual=%h required=%h", $time, actVec, e);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: stimulus did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [6:0] opc;
    int r;
    doReset(1);

    execInstr(T_OPIMM, 0, 0, 1'b0, -1);
    @(negedge clock);
    lit("opimm_rdWrite", {31'd0, rdWriteEnable}, 32'd1);
    lit("opimm_pcSource", {30'd0, pcSource}, 32'd0);
    lit("opimm_retired_in_wb", retiredCount, 32'd0);

    execInstr(T_LOAD, 0, 3, 1'b0, -1);
    @(negedge clock);
    lit("load_rdWrite", {31'd0, rdWriteEnable}, 32'd1);
    lit("load_retired_in_wb", retiredCount, 32'd1);

    execInstr(T_BRANCH, 0, 0, 1'b1, -1);
    @(negedge clock);
    lit("branch_taken_pcSource", {30'd0, pcSource}, 32'd1);
    lit("branch_rdWrite", {31'd0, rdWriteEnable}, 32'd0);
    execInstr(T_BRANCH, 1, 0, 1'b0, -1);
    @(negedge clock);
    lit("branch_not_taken_pcSource", {30'd0, pcSource}, 32'd0);

    execInstr(7'b0000000, 0, 0, 1'b0, -1);
    haltIdle(2);
    @(negedge clock);
    lit("illegal_halted", {31'd0, halted}, 32'd1);
    lit("illegal_fault", {30'd0, faultCode}, 32'd1);
    lit("illegal_retired", retiredCount, 32'd4);

    doReset(1);
    execInstr(T_SYSTEM, 0, 0, 1'b0, -1);
    haltIdle(1);
    @(negedge clock);
    lit("ecall_fault", {30'd0, faultCode}, 32'd3);

    doReset(0);
    execInstr(T_OPIMM, 10, 0, 1'b0, -1);
    haltIdle(2);
    @(negedge clock);
    lit("timeout_fault", {30'd0, faultCode}, 32'd2);

    doReset(0);
    execInstr(T_OPIMM, 3, 0, 1'b0, -1);
    @(negedge clock);
    lit("boundary_no_fault", {30'd0, faultCode}, 32'd0);
    lit("boundary_rdWrite", {31'd0, rdWriteEnable}, 32'd1);

    execInstr(T_STORE, 0, 5, 1'b0, 2);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 19);
      if (r < 17) opc = EXEC_OPS[$urandom_range(0, 9)];
      else if (r == 17) opc = T_SYSTEM;
      else opc = rndOpc();
      execInstr(opc,
                ($urandom_range(0, 4) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 2),
                ($urandom_range(0, 4) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 2),
                rb(),
                ($urandom_range(0, 15) == 0) ? $urandom_range(0, 1) : -1);
      if (mHalted) begin
        haltIdle($urandom_range(1, 3));
        doReset($urandom_range(0, 2));
      end
    end

    @(negedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
